afifo_wr_packer: RTL and testbench
==================================

# afifo_wr_packer

Write-side packer in the `wclk` domain that sits directly upstream of the asynchronous FIFO. It accepts narrow beats on a valid/ready stream and packs RATIO = OUT_W/IN_W beats into one FIFO word. It drives the FIFO write port (`fifo_wen`, `fifo_data`) and honours `fifo_full`. A one-word output register plus a one-word accumulator give full beat throughput while the FIFO is not full.

## Interface
- `IN_W`, default 2: input beat width; OUT_W/IN_W must be an integer power of two ≥ 2.
- `OUT_W`, default 8: FIFO data width (word width).
- `CNT_W`, default 16: width of `words_written`.

Ports:
- `wclk`  in  1  write-domain clock.
- `rst`  in  1  reset, synchronous, active-high; clock `wclk`.
- `s_valid`  in  1  input beat valid.
- `s_data`  in  IN_W  input beat.
- `s_last`  in  1  final beat of a frame; flushes a partial word.
- `s_ready`  out  1  beat accepted at an edge where `s_valid && s_ready`.
- `fifo_full`  in  1  FIFO full flag, wclk domain.
- `fifo_wen`  out  1  FIFO write enable.
- `fifo_data`  out  OUT_W  FIFO write data.
- `words_written`  out  CNT_W  count of words written, wraps.
- `busy`  out  1  partial word, pending word, or output word held.

## Operation
- Internal state:
  - accumulator `acc[OUT_W]`;
  - beat index `cnt` (0..RATIO-1);
  - `acc_done` flag, meaning a word is complete but not yet moved;
  - output register `out_data` and `out_valid`.
- Packing order: beat 0 goes to `acc[IN_W-1:0]`, beat n to `acc[(n+1)*IN_W-1 : n*IN_W]`.
- `fire = out_valid && !fifo_full`. `fifo_wen = fire` (combinational). `fifo_data = out_data`.
- `s_ready = !acc_done && !rst` (registered term only, apart from rst).
- On an accepted beat:
  - Write the beat into its slot. The word completes if `cnt == RATIO-1` or `s_last`.
  - On completion with `s_last` at `cnt < RATIO-1`, all unfilled upper slots are zero.
  - Completed word, output slot free (`!out_valid || fire`): load `out_data`, set `out_valid`, clear `acc`, set `cnt = 0`.
  - Completed word, output slot occupied: set `acc_done`; `acc` is held; `s_ready` drops next cycle.
  - Word not complete: `cnt` increments.
- With `acc_done` set, at the first edge where `!out_valid || fire`: move `acc` to `out_data`, clear `acc_done` and `acc`, set `cnt = 0`.
- `out_valid` clears on `fire` unless a new word loads at the same edge. In that case it stays 1 with the new data.
- `words_written` increments on each `fire`; wraps from all-ones to 0.
- `busy = (cnt != 0) || acc_done || out_valid`.

## Timing
- Reset values, at the first edge with `rst` high:
  - `out_valid = 0`, so `fifo_wen = 0`; `fifo_data = 0`.
  - `acc = 0`, `cnt = 0`, `acc_done = 0`.
  - `words_written = 0`, `busy = 0`.
  - `s_ready = 0` while `rst` is high, and 1 in the first cycle after.
- Reset mid-operation discards the partial word, pending word and held word. Nothing is written after the reset edge.
- Latency: a word completed at edge k has `fifo_wen` high during cycle k+1 (if not full). The FIFO captures it at edge k+1.
- Throughput: one beat per cycle sustained while `fifo_full` is low. No bubble at word boundaries.
- `fifo_full` high: `out_data` held stable, `fifo_wen` low. Input continues until `acc` completes, then `s_ready` deasserts. Back-pressure depth is 2 words.
- `fifo_full` falling: the write occurs in the same cycle, since `fire` is combinational. The pending word moves to the output at that edge. `s_ready` rises the cycle after.
- `s_last` on beat RATIO-1: normal completion, no padding. `s_last` on beat 0: word = beat, zero-padded.
- `fifo_data` never changes while `out_valid && fifo_full`.

## Structure
- Shared package `afifo_pkg`:
  - localparam `RATIO = OUT_W/IN_W`;
  - `CNT_IDX_W = $clog2(RATIO)`;
  - elaboration check that `OUT_W % IN_W == 0` and RATIO is a power of two ≥ 2.
- Single module; no sub-module required. The output register stage may be split as `afifo_wr_outreg` if reused on the read side.

## Test plan
- Reset, then 4 beats `s_data` = 2'b01, 2'b10, 2'b11, 2'b00 with `fifo_full` = 0 -> `fifo_wen` pulses one cycle after beat 4 with `fifo_data` = 8'h39; `words_written` = 1.
- 16 back-to-back beats, `s_valid` constant, `fifo_full` = 0 -> 4 writes, `s_ready` never low, writes spaced exactly 4 cycles apart.
- Hold `fifo_full` = 1, stream 12 beats -> `s_ready` low after beat 8; `fifo_data` stable; release full -> two consecutive `fifo_wen` cycles, then beats 9-12 accepted, third word written.
- 3 beats 2'b11 with `s_last` on the third -> `fifo_data` = 8'h3F, `cnt` back to 0; next beat lands in bits [1:0].
- Assert `rst` for one cycle with a partial word and a pending word while full -> after reset: `busy` = 0, `fifo_wen` never asserts, `words_written` = 0; a following 4-beat word is written alone.
- Preload `words_written` to all-ones by streaming words, then one more write -> `words_written` = 0.

Source files
------------

// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
// Shared definitions for the asynchronous FIFO write/read side logic.
//
// Contents:
//   DEF_IN_W, DEF_OUT_W, DEF_CNT_W : default widths of the write packer
//   RATIO, CNT_IDX_W               : beats per word and beat-index width for
//                                    the default widths
//   calc_ratio()                   : beats per word for arbitrary widths
//   ratio_ok()                     : legality test used by the elaboration
//                                    checks in the modules that import this
// -----------------------------------------------------------------------------
package afifo_pkg;

  localparam int DEF_IN_W  = 2;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_CNT_W = 16;

  localparam int RATIO     = DEF_OUT_W / DEF_IN_W;
  localparam int CNT_IDX_W = $clog2(RATIO);

  // Number of narrow beats packed into one FIFO word.
  function automatic int calc_ratio(input int out_w, input int in_w);
    return (in_w > 0) ? (out_w / in_w) : 0;
  endfunction

  // A word must hold a whole number of beats, and that number must be a
  // power of two of at least 2 so the beat index wraps naturally.
  function automatic bit ratio_ok(input int out_w, input int in_w);
    int r;
    if (in_w <= 0 || out_w <= 0) return 1'b0;
    if ((out_w % in_w) != 0) return 1'b0;
    r = out_w / in_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

endpackage

// File: rtl/afifo_wr_outreg.sv
// -----------------------------------------------------------------------------
// afifo_wr_outreg
// One-word output holding register in front of the FIFO write port, plus the
// count of words actually written.
//
// Ports:
//   wclk, rst      : clock, synchronous active-high reset
//   load           : capture load_data into the register this edge
//   load_data      : word to capture
//   fifo_full      : FIFO full flag; the held word is not written while high
//   out_valid      : register holds a word not yet written
//   fire           : the held word is written this cycle (combinational)
//   fifo_data      : FIFO write data, always the held word
//   words_written  : count of fire cycles, wraps
// -----------------------------------------------------------------------------
module afifo_wr_outreg
  import afifo_pkg::*;
#(
  parameter int DATA_W = DEF_OUT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              wclk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fifo_full,
  output logic              out_valid,
  output logic              fire,
  output logic [DATA_W-1:0] fifo_data,
  output logic [CNT_W-1:0]  words_written
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  words_q,     words_d;

  // The write happens in the same cycle the FIFO has room, so fire is a
  // purely combinational function of the held flag and the full flag.
  assign fire = out_valid_q && !fifo_full;

  // A load at the same edge as a fire replaces the departing word, keeping
  // out_valid high with no bubble between consecutive words.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    words_d     = words_q;

    if (fire) begin
      out_valid_d = 1'b0;
      words_d     = words_q + CNT_W'(1);
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end

    if (rst) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      words_d     = '0;
    end
  end

  always_ff @(posedge wclk) begin
    out_valid_q <= out_valid_d;
    out_data_q  <= out_data_d;
    words_q     <= words_d;
  end

  assign out_valid     = out_valid_q;
  assign fifo_data     = out_data_q;
  assign words_written = words_q;

endmodule

// File: rtl/afifo_wr_packer.sv
// -----------------------------------------------------------------------------
// afifo_wr_packer
// Write-side packer upstream of the asynchronous FIFO. Narrow beats arriving
// on a valid/ready stream are packed, beat 0 in the least significant slot,
// into OUT_W-bit words. A frame-final beat (s_last) closes a partial word with
// the unfilled upper slots zero. One accumulator plus one output word give
// full beat throughput while the FIFO has room and two words of slack when
// it does not.
//
// Ports:
//   wclk, rst      : clock, synchronous active-high reset
//   s_valid        : input beat valid
//   s_data         : input beat (IN_W bits)
//   s_last         : final beat of a frame, flushes a partial word
//   s_ready        : beat accepted at an edge where s_valid && s_ready
//   fifo_full      : FIFO full flag (wclk domain)
//   fifo_wen       : FIFO write enable
//   fifo_data      : FIFO write data (OUT_W bits)
//   words_written  : count of words written to the FIFO, wraps
//   busy           : partial word, pending word or output word present
// -----------------------------------------------------------------------------
module afifo_wr_packer
  import afifo_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             wclk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             fifo_wen,
  output logic [OUT_W-1:0] fifo_data,
  output logic [CNT_W-1:0] words_written,
  output logic             busy
);

  localparam int WORD_RATIO = calc_ratio(OUT_W, IN_W);
  localparam int IDX_W      = (WORD_RATIO >= 2) ? $clog2(WORD_RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_RATIO - 1);

  if (!ratio_ok(OUT_W, IN_W)) begin : g_ratio_check
    $error("afifo_wr_packer: OUT_W/IN_W must be an integer power of two >= 2");
  end

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             acc_done_q, acc_done_d;

  logic             accept;
  logic             word_done;
  logic             slot_free;
  logic [OUT_W-1:0] acc_beat;
  logic             load;
  logic [OUT_W-1:0] load_data;
  logic             out_valid;
  logic             fire;

  // While a finished word waits in the accumulator there is nowhere to put a
  // new beat, so ready depends only on that registered flag (and reset).
  assign s_ready = !acc_done_q && !rst;
  assign accept  = s_valid && s_ready;

  // Accumulator contents with the incoming beat placed in its slot. A frame
  // end also forces every slot above the current one to zero so a short word
  // is always zero-padded regardless of what the accumulator held.
  always_comb begin
    acc_beat = acc_q;
    for (int i = 0; i < WORD_RATIO; i++) begin
      if (cnt_q == IDX_W'(i)) begin
        acc_beat[i*IN_W +: IN_W] = s_data;
      end else if (s_last && (IDX_W'(i) > cnt_q)) begin
        acc_beat[i*IN_W +: IN_W] = '0;
      end
    end
  end

  // Packing control. A pending (acc_done) word has priority for the output
  // register; it can only exist while s_ready is low, so it never competes
  // with a freshly completed word. A completed word goes straight to the
  // output register when that slot is free this edge, otherwise it parks in
  // the accumulator and stalls the input.
  always_comb begin
    word_done  = accept && ((cnt_q == LAST_IDX) || s_last);
    slot_free  = !out_valid || fire;

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_done_d = acc_done_q;
    load       = 1'b0;
    load_data  = acc_q;

    if (acc_done_q) begin
      if (slot_free) begin
        load       = 1'b1;
        load_data  = acc_q;
        acc_d      = '0;
        cnt_d      = '0;
        acc_done_d = 1'b0;
      end
    end else if (word_done) begin
      if (slot_free) begin
        load      = 1'b1;
        load_data = acc_beat;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_done_d = 1'b1;
        acc_d      = acc_beat;
      end
    end else if (accept) begin
      acc_d = acc_beat;
      cnt_d = cnt_q + IDX_W'(1);
    end

    if (rst) begin
      acc_d      = '0;
      cnt_d      = '0;
      acc_done_d = 1'b0;
      load       = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    acc_q      <= acc_d;
    cnt_q      <= cnt_d;
    acc_done_q <= acc_done_d;
  end

  afifo_wr_outreg #(
    .DATA_W (OUT_W),
    .CNT_W  (CNT_W)
  ) u_outreg (
    .wclk          (wclk),
    .rst           (rst),
    .load          (load),
    .load_data     (load_data),
    .fifo_full     (fifo_full),
    .out_valid     (out_valid),
    .fire          (fire),
    .fifo_data     (fifo_data),
    .words_written (words_written)
  );

  assign fifo_wen = fire;
  assign busy     = (cnt_q != '0) || acc_done_q || out_valid;

endmodule

// File: tb/tb_afifo_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_afifo_wr_packer
// Scoreboard bench: accepted beats feed a frame-level reference model that
// pushes each expected word into a queue; a monitor pops and compares on
// every FIFO write. Directed sequences cover latency, throughput,
// back-pressure, short frames, reset and counter wrap; a random phase mixes
// valid, last and full. words_written is narrowed so the wrap is reachable.
// -----------------------------------------------------------------------------
module tb_afifo_wr_packer;

  localparam int IN_W  = 2;
  localparam int OUT_W = 8;
  localparam int CNT_W = 6;
  localparam int RATIO = OUT_W / IN_W;

  logic             wclk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic [IN_W-1:0]  s_data;
  logic             s_last;
  logic             s_ready;
  logic             fifo_full;
  logic             fifo_wen;
  logic [OUT_W-1:0] fifo_data;
  logic [CNT_W-1:0] words_written;
  logic             busy;

  afifo_wr_packer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) dut (
    .wclk          (wclk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .fifo_full     (fifo_full),
    .fifo_wen      (fifo_wen),
    .fifo_data     (fifo_data),
    .words_written (words_written),
    .busy          (busy)
  );

  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc = cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [IN_W-1:0]  cur_beats[$];
  logic [OUT_W-1:0] exp_q[$];
  int               model_writes = 0;
  int               accepted = 0;
  int               last_accept_cyc = 0;
  int               wen_log[$];
  logic [OUT_W-1:0] wen_data_log[$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: collect beats of the current word; a word is closed by
  // RATIO beats or by a frame end, and beat i occupies bits [i*IN_W +: IN_W].
  task automatic modelAccept(input logic [IN_W-1:0] d, input logic last);
    logic [OUT_W-1:0] w;
    cur_beats.push_back(d);
    accepted++;
    last_accept_cyc = cyc;
    if (cur_beats.size() == RATIO || last) begin
      w = '0;
      foreach (cur_beats[i]) w = w | (OUT_W'(cur_beats[i]) << (i * IN_W));
      exp_q.push_back(w);
      cur_beats.delete();
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then note at the
  // falling edge whether the beat will be taken at the coming edge.
  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] d,
                               input logic l, input logic f);
    @(posedge wclk);
    #1;
    s_valid   = v;
    s_data    = d;
    s_last    = l;
    fifo_full = f;
    @(negedge wclk);
    if (!rst && s_valid && s_ready) modelAccept(d, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic doReset(input int n);
    @(posedge wclk);
    #1;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fifo_full = 1'b1;
    exp_q.delete();
    cur_beats.delete();
    model_writes = 0;
    repeat (n) @(posedge wclk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every FIFO write must match the oldest expected word, and the
  // word counter must show the number of writes before this one.
  always @(negedge wclk) begin
    if (!rst && fifo_wen) begin
      wen_log.push_back(cyc);
      wen_data_log.push_back(fifo_data);
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got data %0h expected no write", fifo_data);
      end else begin
        checkOutput("fifo_data", {56'b0, fifo_data}, {56'b0, exp_q.pop_front()});
      end
      checkOutput("words_written_at_write", {58'b0, words_written}, {58'b0, CNT_W'(model_writes)});
      model_writes++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc0;
    int k_cyc;
    int changes;
    bit snap_valid;
    logic [OUT_W-1:0] snap;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; fifo_full = 1'b0;

    // Reset state
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    checkOutput("reset_s_ready", s_ready, 0);
    checkOutput("reset_fifo_wen", fifo_wen, 0);
    checkOutput("reset_fifo_data", fifo_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_words_written", words_written, 0);
    @(posedge wclk);
    #1 rst = 1'b0;
    @(negedge wclk);
    checkOutput("s_ready_after_reset", s_ready, 1);

    // Single word, latency and packing order
    wen_log.delete(); wen_data_log.delete();
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    k_cyc = last_accept_cyc;
    idle(3);
    checkOutput("t1_write_count", wen_log.size(), 1);
    checkOutput("t1_latency", (wen_log.size() > 0) ? wen_log[0] : -1, k_cyc + 1);
    checkOutput("t1_data", (wen_data_log.size() > 0) ? wen_data_log[0] : 'x, 8'h39);
    checkOutput("t1_words_written", words_written, 1);

    // Back-to-back stream: full throughput, writes every RATIO cycles
    wen_log.delete(); wen_data_log.delete();
    acc0 = accepted;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b0);
    checkOutput("t2_beats_accepted", accepted - acc0, 16);
    idle(3);
    checkOutput("t2_write_count", wen_log.size(), 4);
    for (int i = 1; i < wen_log.size(); i++)
      checkOutput("t2_write_spacing", wen_log[i] - wen_log[i-1], RATIO);

    // Back-pressure: two words of slack, then stall with stable data
    wen_log.delete(); wen_data_log.delete();
    acc0 = accepted; changes = 0; snap_valid = 1'b0; snap = '0;
    for (int c = 0; c < 16; c++) begin
      applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b1);
      if (accepted - acc0 >= 5) begin
        if (!snap_valid) begin
          snap = fifo_data;
          snap_valid = 1'b1;
        end else if (fifo_data !== snap) begin
          changes++;
        end
      end
    end
    checkOutput("t3_accepted_while_full", accepted - acc0, 8);
    checkOutput("t3_s_ready_low", s_ready, 0);
    checkOutput("t3_data_changes_while_full", changes, 0);
    checkOutput("t3_no_write_while_full", wen_log.size(), 0);
    for (int c = 0; c < 12; c++)
      applyStimulus((accepted - acc0) < 12, IN_W'($urandom), 1'b0, 1'b0);
    checkOutput("t3_accepted_total", accepted - acc0, 12);
    checkOutput("t3_write_count", wen_log.size(), 3);
    checkOutput("t3_consecutive_writes",
                (wen_log.size() > 1) ? wen_log[1] - wen_log[0] : -1, 1);

    // Short frame: zero padding, next word starts in slot 0
    wen_log.delete(); wen_data_log.delete();
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
    idle(2);
    checkOutput("t4_busy_after_flush", busy, 0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    idle(3);
    checkOutput("t4_write_count", wen_log.size(), 2);
    checkOutput("t4_short_word", (wen_data_log.size() > 0) ? wen_data_log[0] : 'x, 8'h3F);
    checkOutput("t4_next_word", (wen_data_log.size() > 1) ? wen_data_log[1] : 'x, 8'h01);

    // Reset with output and pending words held
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b1);
    checkOutput("t5_busy_before_reset", busy, 1);
    doReset(1);
    wen_log.delete(); wen_data_log.delete();
    idle(6);
    checkOutput("t5_no_write_after_reset", wen_log.size(), 0);
    checkOutput("t5_busy_after_reset", busy, 0);
    checkOutput("t5_words_after_reset", words_written, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b0);
    idle(3);
    checkOutput("t5_single_write", wen_log.size(), 1);
    checkOutput("t5_words_written", words_written, 1);

    // Random mix of valid, last and full
    for (int c = 0; c < 600; c++)
      applyStimulus($urandom_range(0, 99) < 80, IN_W'($urandom),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    acc0 = accepted;
    for (int c = 0; c < 6; c++)
      applyStimulus(accepted == acc0, IN_W'($urandom), 1'b1, 1'b0);
    idle(8);
    checkOutput("rand_final_accepted", accepted - acc0, 1);
    checkOutput("rand_drained", exp_q.size(), 0);
    checkOutput("rand_busy_idle", busy, 0);

    // Counter wrap
    doReset(1);
    for (int w = 0; w < (1 << CNT_W) - 1; w++)
      for (int b = 0; b < RATIO; b++) applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b0);
    idle(3);
    checkOutput("wrap_all_ones", words_written, (1 << CNT_W) - 1);
    for (int b = 0; b < RATIO; b++) applyStimulus(1'b1, IN_W'($urandom), 1'b0, 1'b0);
    idle(3);
    checkOutput("wrap_to_zero", words_written, 0);
    checkOutput("wrap_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
